mem_stage: RTL

- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM register outputs (ALU result, store operand, destination register, control lines) and performs byte/half/word loads and stores against an internal data memory.
- Drives the MEM/WB pipeline register consumed by write-back.
- Combinationally exposes the current ALU result for EX forwarding.

---
 rtl/pipeline_pkg.sv | 39 +++
 rtl/data_memory.sv | 58 +++++
 rtl/mem_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants, load/store size encodings and size/lane decode helpers.
package pipeline_pkg;

    localparam int unsigned INST_SZ          = 32;
    localparam int unsigned REG_ADDR_SZ      = 5;
    localparam int unsigned BHW_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        BHW_BYTE = 2'b00,
        BHW_HALF = 2'b01,
        BHW_WORD = 2'b11
    } bhw_size_e;

    // Reserved size 2'b10 is reported as misaligned so it can never touch memory.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        mis = 1'b1;
        case (size)
            BHW_BYTE: mis = 1'b0;
            BHW_HALF: mis = lane[0];
            BHW_WORD: mis = (lane != 2'b00);
            default:  mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            BHW_BYTE: be = 4'(4'b0001 << lane);
            BHW_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            BHW_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory with byte-lane write enables and a combinational read port.
// MEM_DEBUG_PORT_EN adds a registered debug read port for memory dumps.
module data_memory #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_we,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0]     i_debug_addr,
    input  logic                  i_debug_rd,
    output logic [DATA_W-1:0]     o_debug_data
`endif
);

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned NUM_LANES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Async clear wins over any write on the same edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int w = 0; w < int'(DEPTH); w++) begin
                r_mem[w] <= '0;
            end
        end else if (i_we) begin
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                if (i_be[l]) begin
                    r_mem[i_addr][l*8 +: 8] <= i_wdata[l*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

`ifdef MEM_DEBUG_PORT_EN
    logic [DATA_W-1:0] r_debug_data;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_debug_data <= '0;
        end else if (i_debug_rd) begin
            r_debug_data <= r_mem[i_debug_addr];
        end
    end

    assign o_debug_data = r_debug_data;
`endif

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: alignment check, lane decode, load extension and MEM/WB register.
// MEM_DEBUG_PORT_EN exposes the data memory debug read port.
module mem_stage #(
    parameter int unsigned INST_SZ     = 32,
    parameter int unsigned MEM_ADDR_SZ = 8,
    parameter int unsigned BHW_SZ      = 3
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [INST_SZ-1:0]                  i_alu_result_M,
    input  logic [INST_SZ-1:0]                  i_operand_b_M,
    input  logic [pipeline_pkg::REG_ADDR_SZ-1:0] i_instr_rd_M,
    input  logic                                i_mem_read_MC,
    input  logic                                i_mem_write_MC,
    input  logic                                i_mem_to_reg_MC,
    input  logic                                i_reg_write_MC,
    input  logic [BHW_SZ-1:0]                   i_bhw_MC,
    input  logic                                i_halt,
    input  logic                                i_flush,
`ifdef MEM_DEBUG_PORT_EN
    input  logic [MEM_ADDR_SZ-1:0]              i_debug_addr,
    input  logic                                i_debug_rd,
    output logic [INST_SZ-1:0]                  o_debug_data,
`endif
    output logic [INST_SZ-1:0]                  o_alu_result_fwd_M,
    output logic [INST_SZ-1:0]                  o_read_data_W,
    output logic [INST_SZ-1:0]                  o_alu_result_W,
    output logic [pipeline_pkg::REG_ADDR_SZ-1:0] o_instr_rd_W,
    output logic                                o_reg_write_W,
    output logic                                o_mem_to_reg_W,
    output logic                                o_misaligned_W
);

    import pipeline_pkg::BHW_BYTE;
    import pipeline_pkg::BHW_HALF;
    import pipeline_pkg::BHW_WORD;
    import pipeline_pkg::BHW_UNSIGNED_BIT;
    import pipeline_pkg::REG_ADDR_SZ;
    import pipeline_pkg::is_misaligned;
    import pipeline_pkg::lane_enables;

    logic [1:0]             w_lane;
    logic [1:0]             w_size;
    logic                   w_unsigned;
    logic [MEM_ADDR_SZ-1:0] w_word_idx;
    logic                   w_misaligned;
    logic                   w_access;
    logic                   w_store_en;
    logic [3:0]             w_be;
    logic [INST_SZ-1:0]     w_wdata;
    logic [INST_SZ-1:0]     w_rdata;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [INST_SZ-1:0]     w_load_data;
    logic                   w_reg_write;

    logic [INST_SZ-1:0]     r_read_data;
    logic [INST_SZ-1:0]     r_alu_result;
    logic [REG_ADDR_SZ-1:0] r_instr_rd;
    logic                   r_reg_write;
    logic                   r_mem_to_reg;
    logic                   r_misaligned;

    assign o_alu_result_fwd_M = i_alu_result_M;

    // Upper address bits are dropped so accesses wrap modulo the memory size.
    assign w_lane     = i_alu_result_M[1:0];
    assign w_word_idx = i_alu_result_M[MEM_ADDR_SZ+1:2];
    assign w_size     = i_bhw_MC[1:0];
    assign w_unsigned = i_bhw_MC[BHW_UNSIGNED_BIT];

    assign w_access     = i_mem_read_MC | i_mem_write_MC;
    assign w_misaligned = w_access & is_misaligned(w_size, w_lane);
    assign w_store_en   = i_mem_write_MC & ~w_misaligned & ~i_halt & ~i_flush;
    assign w_be         = lane_enables(w_size, w_lane);

    // Replicate store data across lanes; byte enables pick the target lane(s).
    always_comb begin
        w_wdata = i_operand_b_M;
        case (w_size)
            BHW_BYTE: w_wdata = INST_SZ'({4{i_operand_b_M[7:0]}});
            BHW_HALF: w_wdata = INST_SZ'({2{i_operand_b_M[15:0]}});
            default:  w_wdata = i_operand_b_M;
        endcase
    end

    data_memory #(
        .DATA_W (INST_SZ),
        .ADDR_W (MEM_ADDR_SZ)
    ) u_data_memory (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_addr       (w_word_idx),
        .i_we         (w_store_en),
        .i_be         (w_be),
        .i_wdata      (w_wdata),
        .o_rdata      (w_rdata)
`ifdef MEM_DEBUG_PORT_EN
        ,
        .i_debug_addr (i_debug_addr),
        .i_debug_rd   (i_debug_rd),
        .o_debug_data (o_debug_data)
`endif
    );

    always_comb begin
        w_byte = w_rdata[31:24];
        case (w_lane)
            2'd0:    w_byte = w_rdata[7:0];
            2'd1:    w_byte = w_rdata[15:8];
            2'd2:    w_byte = w_rdata[23:16];
            default: w_byte = w_rdata[31:24];
        endcase
    end

    assign w_half = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];

    // Read data comes from pre-write contents, so same-cycle store returns old data.
    always_comb begin
        w_load_data = '0;
        if (i_mem_read_MC && !w_misaligned) begin
            case (w_size)
                BHW_BYTE: w_load_data = {{(INST_SZ-8){w_byte[7] & ~w_unsigned}}, w_byte};
                BHW_HALF: w_load_data = {{(INST_SZ-16){w_half[15] & ~w_unsigned}}, w_half};
                BHW_WORD: w_load_data = w_rdata;
                default:  w_load_data = '0;
            endcase
        end
    end

    assign w_reg_write = i_reg_write_MC & ~(i_mem_read_MC & w_misaligned);

    // MEM/WB register: reset > halt (hold) > flush (bubble) > capture.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_instr_rd   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (i_halt) begin
            r_read_data  <= r_read_data;
            r_alu_result <= r_alu_result;
            r_instr_rd   <= r_instr_rd;
            r_reg_write  <= r_reg_write;
            r_mem_to_reg <= r_mem_to_reg;
            r_misaligned <= r_misaligned;
        end else if (i_flush) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_instr_rd   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_read_data  <= w_load_data;
            r_alu_result <= i_alu_result_M;
            r_instr_rd   <= i_instr_rd_M;
            r_reg_write  <= w_reg_write;
            r_mem_to_reg <= i_mem_to_reg_MC;
            r_misaligned <= w_misaligned;
        end
    end

    assign o_read_data_W  = r_read_data;
    assign o_alu_result_W = r_alu_result;
    assign o_instr_rd_W   = r_instr_rd;
    assign o_reg_write_W  = r_reg_write;
    assign o_mem_to_reg_W = r_mem_to_reg;
    assign o_misaligned_W = r_misaligned;

endmodule
